// File: rtl/window_frame_buffer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : window_frame_buffer_pkg
// Description : Shared frame geometry for the window / frame buffer / FFT path
//               plus a saturating counter helper.
// Revision    : 1.0 - initial release
// ============================================================================
package window_frame_buffer_pkg;

  localparam int FRAME_N  = 1024;  // samples per windowed frame
  localparam int SAMPLE_W = 14;    // signed sample width
  localparam int DROP_W   = 8;     // dropped-frame counter width

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [DROP_W-1:0] sat_inc(input logic [DROP_W-1:0] v);
    return (v == '1) ? v : v + DROP_W'(1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/window_frame_buffer_frame_ram.sv
`default_nettype none
// ============================================================================
// Module      : window_frame_buffer_frame_ram
// Description : Simple dual-port RAM holding both frame banks, addressed as
//               {bank, index}. One write port, one registered read port.
// Revision    : 1.0 - initial release
// ============================================================================
module window_frame_buffer_frame_ram
  import window_frame_buffer_pkg::*;
#(
  parameter int ADDR_W     = 11,
  parameter int DATA_WIDTH = SAMPLE_W
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_W-1:0]     waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  re,
  input  logic [ADDR_W-1:0]     raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] r_mem [2**ADDR_W];

  // Write port: contents are never cleared, reset only affects control state.
  always_ff @(posedge clk) begin
    if (we) r_mem[waddr] <= wdata;
  end

  // Read port: one-cycle latency so the array maps onto block RAM.
  always_ff @(posedge clk) begin
    if (re) rdata <= r_mem[raddr];
  end

endmodule
`default_nettype wire

// File: rtl/window_frame_buffer.sv
`default_nettype none
// ============================================================================
// Module      : window_frame_buffer
// Description : Ping-pong capture of windowed frames into two RAM banks and
//               replay of completed frames over a valid/ready stream, with
//               whole-frame drop accounting when both banks are occupied.
// Revision    : 1.0 - initial release
// ============================================================================
module window_frame_buffer
  import window_frame_buffer_pkg::*;
#(
  parameter int N          = FRAME_N,
  parameter int DATA_WIDTH = SAMPLE_W
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clk_en,
  input  logic                  din_valid,
  input  logic [DATA_WIDTH-1:0] din,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  out_last,
  output logic                  overflow,
  output logic [7:0]            drop_cnt
);

  localparam int            CW     = $clog2(N);
  localparam logic [CW-1:0] C_LAST = CW'(N - 1);

  typedef enum logic [1:0] {
    RD_IDLE   = 2'd0,
    RD_FETCH  = 2'd1,
    RD_STREAM = 2'd2
  } rd_state_t;

  // Bank bookkeeping
  logic [1:0]    r_full;
  logic          r_wr_bank;
  logic          r_rd_bank;
  logic [CW-1:0] r_wr_ctr;
  logic [CW-1:0] r_rd_ctr;      // next index to fetch from the read bank
  logic          r_discard;

  // Read pipeline
  rd_state_t       r_state;
  rd_state_t       w_state_nxt;
  logic            r_pend;        // RAM output holds a fetched sample this cycle
  logic            r_pend_last;
  logic            r_issue_done;  // every index of the current frame fetched
  logic            r_skid_valid;
  logic            r_skid_last;
  logic [DATA_WIDTH-1:0] r_skid_data;
  logic [DATA_WIDTH-1:0] w_ram_q;

  // Write-side decode
  logic w_wr_act;
  logic w_drop_start;
  logic w_dropping;
  logic w_we;
  logic w_set_full;

  // Read-side decode
  logic          w_hs;
  logic          w_frame_end;
  logic [1:0]    w_occ;
  logic          w_credit;
  logic          w_issue;
  logic          w_issue_bank;
  logic [CW-1:0] w_issue_ctr;
  logic          w_issue_last;
  logic          w_free;
  logic [1:0]    w_full_nxt;

  assign w_wr_act     = clk_en & din_valid;
  // Full-check uses the registered flag, so a bank freed this cycle still drops.
  assign w_drop_start = (r_wr_ctr == '0) & r_full[r_wr_bank];
  assign w_dropping   = r_discard | w_drop_start;
  assign w_we         = w_wr_act & ~w_dropping;
  assign w_set_full   = w_we & (r_wr_ctr == C_LAST);

  assign w_hs        = out_valid & out_ready;
  assign w_frame_end = w_hs & out_last;
  // Samples held in output reg, skid reg and RAM output; at most two may be
  // outstanding after this cycle's handshake so the skid never overflows.
  assign w_occ       = {1'b0, out_valid} + {1'b0, r_skid_valid} + {1'b0, r_pend};
  assign w_credit    = (w_occ <= (2'd1 + {1'b0, w_hs}));
  assign w_issue_last = (w_issue_ctr == C_LAST);

  window_frame_buffer_frame_ram #(
    .ADDR_W     (CW + 1),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_frame_ram (
    .clk   (clk),
    .we    (w_we),
    .waddr ({r_wr_bank, r_wr_ctr}),
    .wdata (din),
    .re    (w_issue),
    .raddr ({w_issue_bank, w_issue_ctr}),
    .rdata (w_ram_q)
  );

  // Read FSM next state and RAM fetch requests.
  always_comb begin
    w_state_nxt  = r_state;
    w_issue      = 1'b0;
    w_issue_bank = r_rd_bank;
    w_issue_ctr  = r_rd_ctr;
    w_free       = 1'b0;
    case (r_state)
      RD_IDLE: begin
        if (r_full[r_rd_bank]) begin
          w_issue     = 1'b1;
          w_issue_ctr = '0;
          w_state_nxt = RD_FETCH;
        end
      end
      RD_FETCH: begin
        w_state_nxt = RD_STREAM;
        if (!r_issue_done && w_credit) w_issue = 1'b1;
      end
      RD_STREAM: begin
        if (w_frame_end) begin
          w_free = 1'b1;
          if (r_full[~r_rd_bank]) begin
            w_issue      = 1'b1;
            w_issue_bank = ~r_rd_bank;
            w_issue_ctr  = '0;
            w_state_nxt  = RD_FETCH;
          end else begin
            w_state_nxt  = RD_IDLE;
          end
        end else if (!r_issue_done && w_credit) begin
          w_issue = 1'b1;
        end
      end
      default: w_state_nxt = RD_IDLE;
    endcase
  end

  // Bank flags: a read freeing one bank and a write filling the other both apply.
  always_comb begin
    w_full_nxt = r_full;
    if (w_free)     w_full_nxt[r_rd_bank] = 1'b0;
    if (w_set_full) w_full_nxt[r_wr_bank] = 1'b1;
  end

  // Write counter, bank toggle, discard and drop accounting.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ctr  <= '0;
      r_wr_bank <= 1'b0;
      r_discard <= 1'b0;
      overflow  <= 1'b0;
      drop_cnt  <= '0;
    end else if (w_wr_act) begin
      r_wr_ctr <= r_wr_ctr + CW'(1);
      if (r_wr_ctr == C_LAST) begin
        r_discard <= 1'b0;
        if (!w_dropping) r_wr_bank <= ~r_wr_bank;
      end else if (w_drop_start) begin
        r_discard <= 1'b1;
        overflow  <= 1'b1;
        drop_cnt  <= sat_inc(drop_cnt);
      end
    end
  end

  // Full flags, read FSM state and fetch bookkeeping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_full       <= '0;
      r_state      <= RD_IDLE;
      r_rd_bank    <= 1'b0;
      r_rd_ctr     <= '0;
      r_issue_done <= 1'b0;
      r_pend       <= 1'b0;
      r_pend_last  <= 1'b0;
    end else begin
      r_full      <= w_full_nxt;
      r_state     <= w_state_nxt;
      r_pend      <= w_issue;
      r_pend_last <= w_issue & w_issue_last;
      if (w_free) r_rd_bank <= ~r_rd_bank;
      if (w_issue) begin
        r_rd_ctr     <= w_issue_ctr + CW'(1);
        r_issue_done <= w_issue_last;
      end else if (w_free) begin
        r_rd_ctr     <= '0;
        r_issue_done <= 1'b0;
      end
    end
  end

  // Output register with one-entry skid; dout/out_last hold while stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid    <= 1'b0;
      out_last     <= 1'b0;
      dout         <= '0;
      r_skid_valid <= 1'b0;
      r_skid_last  <= 1'b0;
      r_skid_data  <= '0;
    end else if (!out_valid || w_hs) begin
      if (r_skid_valid) begin
        out_valid    <= 1'b1;
        dout         <= r_skid_data;
        out_last     <= r_skid_last;
        r_skid_valid <= r_pend;
        r_skid_data  <= w_ram_q;
        r_skid_last  <= r_pend_last;
      end else if (r_pend) begin
        out_valid <= 1'b1;
        dout      <= w_ram_q;
        out_last  <= r_pend_last;
      end else begin
        out_valid <= 1'b0;
        out_last  <= 1'b0;
      end
    end else if (r_pend) begin
      r_skid_valid <= 1'b1;
      r_skid_data  <= w_ram_q;
      r_skid_last  <= r_pend_last;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_window_frame_buffer.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_window_frame_buffer
// Description : Self-checking bench: frame-level reference model with a
//               per-cycle compare process, directed and randomized scenarios.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_window_frame_buffer;

  localparam int N  = 8;
  localparam int DW = 14;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          clk_en = 1'b0;
  logic          din_valid = 1'b0;
  logic [DW-1:0] din = '0;
  logic          out_ready = 1'b0;
  logic          out_valid;
  logic [DW-1:0] dout;
  logic          out_last;
  logic          overflow;
  logic [7:0]    drop_cnt;

  always #5 clk = ~clk;

  window_frame_buffer #(.N(N), .DATA_WIDTH(DW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .clk_en    (clk_en),
    .din_valid (din_valid),
    .din       (din),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .dout      (dout),
    .out_last  (out_last),
    .overflow  (overflow),
    .drop_cnt  (drop_cnt)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: actual=%0d required=%0d at %0t", name, act, exp, $time);
  endtask

  // Reference model: frames as sample lists, buffered-frame count, drop count.
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] m_cur[$];
  int            m_ridx = 0;
  int            m_nbuf = 0;
  int            m_wn = 0;
  bit            m_wdrop = 0;
  int            m_drops = 0;
  bit            m_over = 0;
  int            n_hs = 0;
  logic [DW-1:0] got_q[$];
  bit            got_last_q[$];
  bit            prev_stall = 0;
  logic [DW-1:0] prev_dout = '0;
  logic          prev_last = 1'b0;
  int            ready_mode = 0;
  int            rphase = 0;

  // Compare DUT to model, then advance the model by the coming clock edge.
  always @(negedge clk) begin
    int nb_pre;
    if (!rst_n) begin
      exp_q.delete();
      m_cur.delete();
      m_ridx = 0; m_nbuf = 0; m_wn = 0; m_wdrop = 0;
      m_drops = 0; m_over = 0; prev_stall = 0;
    end else begin
      chk("overflow", overflow, m_over);
      chk("drop_cnt", drop_cnt, (m_drops > 255) ? 255 : m_drops);
      if (prev_stall) begin
        chk("stall_valid", out_valid, 1);
        chk("stall_dout", dout, prev_dout);
        chk("stall_last", out_last, prev_last);
      end
      if (m_ridx != 0) chk("mid_frame_bubble", out_valid, 1);
      if (out_valid) begin
        if (exp_q.size() == 0) chk("spurious_valid", out_valid, 0);
        else begin
          chk("dout", $signed(dout), $signed(exp_q[0]));
          chk("out_last", out_last, m_ridx == N - 1);
        end
      end
      nb_pre = m_nbuf;
      if (clk_en && din_valid) begin
        if (m_wn == 0) begin
          m_cur.delete();
          m_wdrop = (nb_pre == 2);
          if (m_wdrop) begin m_over = 1; m_drops++; end
        end
        if (!m_wdrop) m_cur.push_back(din);
        m_wn++;
        if (m_wn == N) begin
          m_wn = 0;
          if (!m_wdrop) begin
            foreach (m_cur[i]) exp_q.push_back(m_cur[i]);
            m_nbuf++;
          end
        end
      end
      if (out_valid && out_ready && exp_q.size() > 0) begin
        got_q.push_back(dout);
        got_last_q.push_back(out_last);
        n_hs++;
        void'(exp_q.pop_front());
        m_ridx++;
        if (m_ridx == N) begin m_ridx = 0; m_nbuf--; end
      end
      prev_stall = out_valid && !out_ready;
      prev_dout  = dout;
      prev_last  = out_last;
    end
  end

  // Consumer ready: always, 1-0-0 pattern, random, or never.
  always @(posedge clk) begin
    #1;
    case (ready_mode)
      0: out_ready = 1'b1;
      1: begin out_ready = (rphase % 3 == 0); rphase++; end
      2: out_ready = 1'($urandom_range(0, 1));
      default: out_ready = 1'b0;
    endcase
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_cycles(input int n);
    clk_en = 1'b0; din_valid = 1'b0;
    repeat (n) step();
  endtask

  task automatic send_sample(input logic [DW-1:0] v, input int gap_max, input bit gate4);
    int g;
    g = gate4 ? 3 : ((gap_max > 0) ? int'($urandom_range(0, gap_max)) : 0);
    for (int i = 0; i < g; i++) begin
      if (gate4) begin clk_en = 1'b0; din_valid = 1'b1; end
      else begin clk_en = 1'($urandom_range(0, 1)); din_valid = ~clk_en; end
      din = DW'($urandom);
      step();
    end
    clk_en = 1'b1; din_valid = 1'b1; din = v;
    step();
    clk_en = 1'b0; din_valid = 1'b0;
  endtask

  task automatic send_frame(input int base, input bit rnd, input int gap_max, input bit gate4);
    for (int i = 0; i < N; i++)
      send_sample(rnd ? DW'($urandom) : DW'(base + i), gap_max, gate4);
  endtask

  task automatic drain(input string name);
    int k;
    k = 0;
    ready_mode = 0;
    while ((exp_q.size() != 0 || m_ridx != 0) && k < 400) begin step(); k++; end
    chk({name, "_drain_left"}, exp_q.size(), 0);
    step(); step();
    chk({name, "_idle_valid"}, out_valid, 0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    chk("reset_out_valid_async", out_valid, 0);
    repeat (3) step();
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $display("%0d/%0d checks passed", n_pass, n_checks + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    int h0;
    int k;
    // Reset state
    repeat (3) step();
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_last", out_last, 0);
    chk("rst_dout", dout, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_drop_cnt", drop_cnt, 0);
    rst_n = 1'b1;
    step();

    // Single frame -4..3, latency and order pinned literally
    ready_mode = 0;
    got_q.delete(); got_last_q.delete();
    send_frame(-4, 0, 0, 0);
    chk("s1_lat_t0", out_valid, 0);
    step();
    chk("s1_lat_t1", out_valid, 0);
    step();
    chk("s1_lat_t2", out_valid, 1);
    drain("s1");
    chk("s1_count", got_q.size(), 8);
    for (int i = 0; i < N && i < got_q.size(); i++) begin
      chk("s1_data", $signed(got_q[i]), -4 + i);
      chk("s1_last", got_last_q[i], (i == 7) ? 1 : 0);
    end

    // Back-pressure 1,0,0 pattern
    h0 = n_hs;
    ready_mode = 1;
    send_frame(0, 1, 0, 0);
    send_frame(0, 1, 1, 0);
    drain("s2");
    chk("s2_count", n_hs - h0, 16);

    // Overflow: three frames with no consumer
    h0 = n_hs;
    got_q.delete();
    ready_mode = 3;
    send_frame(100, 0, 0, 0);
    send_frame(200, 0, 0, 0);
    send_frame(300, 0, 0, 0);
    idle_cycles(4);
    chk("s3_drop_cnt", drop_cnt, 1);
    chk("s3_overflow", overflow, 1);
    chk("s3_held", n_hs - h0, 0);
    drain("s3");
    chk("s3_count", got_q.size(), 16);
    if (got_q.size() == 16) begin
      chk("s3_first", got_q[0], 100);
      chk("s3_second", got_q[8], 200);
      chk("s3_end", got_q[15], 207);
    end

    // Rate gating: clk_en every 4th cycle, din_valid held high
    h0 = n_hs;
    send_frame(20, 0, 0, 1);
    drain("s4");
    chk("s4_count", n_hs - h0, 8);

    // Randomized traffic, gaps and back-pressure
    for (int f = 0; f < 30; f++) begin
      ready_mode = int'($urandom_range(0, 2));
      send_frame(0, 1, int'($urandom_range(0, 3)), 0);
    end
    drain("rand");

    // Async reset mid-readout at sample 4
    ready_mode = 0;
    send_frame(50, 0, 0, 0);
    k = 0;
    while (!out_valid && k < 10) begin step(); k++; end
    chk("s6_started", out_valid, 1);
    repeat (4) step();
    chk("s6_sample4", dout, 54);
    do_reset();
    chk("s6_overflow", overflow, 0);
    got_q.delete();
    send_frame(60, 0, 0, 0);
    drain("s6");
    chk("s6_count", got_q.size(), 8);
    if (got_q.size() > 0) chk("s6_first", got_q[0], 60);

    // Last read of bank 0 coincides with the 8th write of bank 1
    got_q.delete();
    send_frame(0, 0, 0, 0);
    idle_cycles(2);
    for (int i = 0; i < N; i++) begin
      if (i == N - 1) chk("s5_coincide", out_valid && out_last, 1);
      send_sample(DW'(10 + i), 0, 0);
    end
    drain("s5");
    chk("s5_drop_cnt", drop_cnt, 0);
    chk("s5_count", got_q.size(), 16);
    if (got_q.size() == 16) chk("s5_bank1_first", got_q[8], 10);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
